seg7_readback: RTL

Display-bus reader for the board's multiplexed 8-digit seven-segment interface. It watches the active-low anode and cathode lines driven by the display scan logic and decodes each strobed cathode pattern back to a BCD digit. It keeps a per-digit register image with valid/error flags and signals when a full scan frame has been observed. It sits beside the display driver for on-board self-check and for simulation scoreboarding of displayed values, such as the generation count.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_readback_if.sv | 28 ++
 rtl/seg7_to_bcd.sv | 36 +++
 rtl/seg7_readback.sv | 126 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display driver and readback.
// Segment codes are {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;
  localparam logic [6:0] SEG_DEFAULT = 7'b0111111;

  localparam logic [3:0] BCD_OOR = 4'hE;
  localparam logic [3:0] BCD_BAD = 4'hF;

  localparam int CATH_A  = 7;
  localparam int CATH_G  = 1;
  localparam int CATH_DP = 0;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg7_readback_if.sv
// Display bus seen by the readback block: scan lines in, digit image out.
// The master side is the scan logic / observer, the slave side the reader.
interface seg7_readback_if #(
  parameter int NUM_DIGITS = 8
);

  logic [NUM_DIGITS-1:0]   anode;
  logic [7:0]              cathode;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    frame_done;
  logic                    ghost_err;

  modport master (
    output anode, cathode,
    input  digits, digit_valid, digit_err,
    input  dp, frame_done, ghost_err
  );

  modport slave (
    input  anode, cathode,
    output digits, digit_valid, digit_err,
    output dp, frame_done, ghost_err
  );

endinterface

// File: rtl/seg7_to_bcd.sv
// Seven-segment pattern back to BCD.
// Unknown patterns flag err with a distinct code for the driver's blank.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       err,
  output logic [3:0] bcd
);

  always_comb begin
    err = 1'b0;
    bcd = 4'd0;
    case (seg)
      SEG_0: bcd = 4'd0;
      SEG_1: bcd = 4'd1;
      SEG_2: bcd = 4'd2;
      SEG_3: bcd = 4'd3;
      SEG_4: bcd = 4'd4;
      SEG_5: bcd = 4'd5;
      SEG_6: bcd = 4'd6;
      SEG_7: bcd = 4'd7;
      SEG_8: bcd = 4'd8;
      SEG_9: bcd = 4'd9;
      SEG_DEFAULT: begin
        err = 1'b1;
        bcd = BCD_OOR;
      end
      default: begin
        err = 1'b1;
        bcd = BCD_BAD;
      end
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Multiplexed seven-segment bus reader: settles each strobe,
// decodes it and keeps a per-digit image with frame tracking.
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic      clk,
  input logic      reset,
  seg7_readback_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   r_anode, p_anode;
  logic [7:0]              r_cathode, p_cathode;
  state_t                  state;
  logic [7:0]              cnt;
  logic [NUM_DIGITS-1:0]   seen;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q, err_q, dp_q;
  logic                    frame_q, ghost_q;

  logic          strobe, multi, same, cap, dec_err;
  logic [IW-1:0] idx;
  logic [3:0]    dec_bcd;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!r_anode[i]) idx = IW'(i);
  end

  assign strobe = $countones(~r_anode) == 1;
  assign multi  = $countones(~r_anode) > 1;
  assign same   = (r_anode == p_anode) &&
                  (r_cathode == p_cathode);
  assign cap    = (state == SETTLE) && strobe &&
                  same && (cnt == LAST);

  seg7_to_bcd u_dec (
    .seg (r_cathode[CATH_A:CATH_G]),
    .err (dec_err),
    .bcd (dec_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode   <= '1;
      p_anode   <= '1;
      r_cathode <= '1;
      p_cathode <= '1;
      state     <= IDLE;
      cnt       <= '0;
      seen      <= '0;
      digits_q  <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      dp_q      <= '0;
      frame_q   <= 1'b0;
      ghost_q   <= 1'b0;
    end else begin
      r_anode   <= bus.anode;
      r_cathode <= bus.cathode;
      p_anode   <= r_anode;
      p_cathode <= r_cathode;
      if (multi) ghost_q <= 1'b1;

      unique case (state)
        IDLE: begin
          if (strobe) begin
            cnt   <= 8'd1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!strobe) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (!same) begin
            cnt <= 8'd1;
          end else begin
            cnt <= cnt + 8'd1;
            if (cap) state <= HOLD;
          end
        end
        HOLD: begin
          if (!same) begin
            cnt   <= strobe ? 8'd1 : 8'd0;
            state <= strobe ? SETTLE : IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase

      if (cap) begin
        digits_q[{idx, 2'b00} +: 4] <= dec_bcd;
        err_q[idx]   <= dec_err;
        dp_q[idx]    <= ~r_cathode[CATH_DP];
        valid_q[idx] <= 1'b1;
      end

      // a capture landing on the completing cycle is not carried over
      if (&seen) begin
        frame_q <= 1'b1;
        seen    <= '0;
      end else begin
        frame_q <= 1'b0;
        if (cap) seen[idx] <= 1'b1;
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.dp          = dp_q;
  assign bus.frame_done  = frame_q;
  assign bus.ghost_err   = ghost_q;

endmodule
